bp_nonsynth_cosim_commit_queue: RTL and testbench
=================================================

// Module: bp_nonsynth_cosim_commit_queue
// PURPOSE
//  Multi-channel commit/writeback reconciler for Dromajo cosimulation.
//  Per channel (one per hart), it buffers retired-instruction records and pairs them with late register writebacks.
//  Completed records are then handed one at a time to the DPI stepping shell over a valid/yumi handshake.
//  Adds round-robin channel arbitration, per-channel finish counting, a stall watchdog and sticky error flags.
// PARAMETERS
//  num_chan_p        1      channels (harts) reconciled
//  els_p             8      entries per channel queue; power of 2, >=2
//  vaddr_width_p     39     PC width
//  instr_width_p     32     instruction width
//  dword_width_p     64     writeback data / cause width
//  timeout_cycles_p  2**20  stall cycles before timeout_o
//  cnt_width_p       32     retire counter / target width
// PORTS
//  clk_i            in   1                    clock, rising edge
//  reset_n_i        in   1                    async active-low reset
//  commit_v_i       in   C                    per-channel commit (C=num_chan_p)
//  commit_pc_i      in   C*vaddr_width_p      committed PC
//  commit_instr_i   in   C*instr_width_p      committed instruction
//  commit_wb_i      in   C                    commit awaits an rd writeback
//  trap_v_i         in   C                    interrupt/trap event (enqueued as record)
//  cause_i          in   C*dword_width_p      trap cause
//  wb_v_i           in   C                    rd writeback valid
//  wb_addr_i        in   C*5                  writeback rd address
//  wb_data_i        in   C*dword_width_p      writeback data
//  target_i         in   C*cnt_width_p        finish retire count; 0 = disabled
//  step_v_o         out  1                    record available
//  step_yumi_i      in   1                    consumer takes record
//  step_chan_o      out  clog2(C)             source channel
//  step_trap_o      out  1                    record is trap (use cause)
//  step_pc_o/_instr_o/_data_o/_cause_o  out   record fields; data=0 if no wb
//  finish_o         out  C                    sticky: channel reached target
//  timeout_o        out  1                    sticky watchdog fire
//  error_o          out  3                    sticky {wb_mismatch, wb_orphan, overflow}
// BEHAVIOUR
//  Reset (async assert, sync release): queues empty, pointers/counters 0, all outputs 0.
//  Enqueue: commit_v_i|trap_v_i writes one entry; trap wins if both set (commit dropped, no error).
//   Trap entries are never wb-pending.
//   Full = occupancy==els_p before this cycle's dequeue.
//   Enqueue while full and not dequeuing -> dropped, error_o[0] set.
//  Writeback: in order per channel; fills oldest wb-pending unfilled entry, including one enqueued same cycle.
//   wb_addr_i != entry instr[11:7] -> data still stored, error_o[2] set.
//   No such entry -> ignored, error_o[1] set.
//  Head ready: valid and (not wb-pending or filled).
//  Arbitration: round-robin from prio pointer over ready heads, combinational to step_v_o.
//   Selection latches once step_v_o is high and holds, fields stable, until step_yumi_i.
//   On yumi: head pops, prio = granted+1 mod C, latch clears; next grant possible next cycle.
//  step_yumi_i without step_v_o is illegal (assertion).
//  Retire count per channel: +1 on yumi of a non-trap record, saturating.
//   finish_o[c] set the cycle after count == target_i[c] != 0; stays set.
//  Watchdog: counter cleared on yumi or when all queues empty, else +1.
//   Reaching timeout_cycles_p sets timeout_o, counter holds.
//  Pointers wrap modulo els_p; occupancy counter width clog2(els_p+1).
//  Reset mid-operation discards all entries; sticky flags clear.
// TESTING
//  C=1: commit pc=0x80000000 wb=0, no yumi hold -> step_v_o next cycle, fields stable 5 cycles, pops on yumi.
//  C=1: commit wb=1 rd=x5, wb 3 cycles later data=0xDEAD -> step_v_o only after wb, step_data_o=0xDEAD.
//  C=2: both ready every cycle, yumi always -> step_chan_o alternates 0,1,0,1.
//  els_p=8: 9 commits, no yumi -> error_o=3'b001, 8 records later drain in order.
//  wb_v_i with empty queue -> error_o=3'b010; wb_addr 6 vs rd x5 -> error_o[2]=1.
//  target_i=4: 4 yumis -> finish_o=1 next cycle.
//  timeout_cycles_p=16: 1 pending record, no yumi -> timeout_o at cycle 16.

Source files
------------

// File: rtl/bp_nonsynth_cosim_commit_queue_if.sv
// Step handshake between the commit queue and the DPI stepping shell.
// The queue (master) offers one completed record at a time; the shell
// (slave) takes it by raising step_yumi_i while step_v_o is high.
interface bp_nonsynth_cosim_commit_queue_if #(
    parameter int num_chan_p    = 1,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dword_width_p = 64,
    parameter int chan_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
);
    logic                     step_v_o;
    logic                     step_yumi_i;
    logic [chan_width_lp-1:0] step_chan_o;
    logic                     step_trap_o;
    logic [vaddr_width_p-1:0] step_pc_o;
    logic [instr_width_p-1:0] step_instr_o;
    logic [dword_width_p-1:0] step_data_o;
    logic [dword_width_p-1:0] step_cause_o;

    modport master (
        output step_v_o, step_chan_o, step_trap_o, step_pc_o,
               step_instr_o, step_data_o, step_cause_o,
        input  step_yumi_i
    );

    modport slave (
        input  step_v_o, step_chan_o, step_trap_o, step_pc_o,
               step_instr_o, step_data_o, step_cause_o,
        output step_yumi_i
    );
endinterface

// File: rtl/bp_nonsynth_cosim_commit_queue.sv
// Commit/writeback reconciler for cosimulation. Each channel (hart) keeps a
// small in-order queue of retired instructions and traps; register
// writebacks arriving later fill the oldest entry still waiting for one.
// Ready heads are arbitrated round-robin and handed out over step_if.
// Also tracks per-channel retire counts against a finish target, a stall
// watchdog and sticky error flags {wb_mismatch, wb_orphan, overflow}.
module bp_nonsynth_cosim_commit_queue #(
    parameter int num_chan_p       = 1,
    parameter int els_p            = 8,
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int dword_width_p    = 64,
    parameter int timeout_cycles_p = 2**20,
    parameter int cnt_width_p      = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_chan_p-1:0]              commit_v_i,
    input  logic [num_chan_p*vaddr_width_p-1:0] commit_pc_i,
    input  logic [num_chan_p*instr_width_p-1:0] commit_instr_i,
    input  logic [num_chan_p-1:0]              commit_wb_i,
    input  logic [num_chan_p-1:0]              trap_v_i,
    input  logic [num_chan_p*dword_width_p-1:0] cause_i,
    input  logic [num_chan_p-1:0]              wb_v_i,
    input  logic [num_chan_p*5-1:0]            wb_addr_i,
    input  logic [num_chan_p*dword_width_p-1:0] wb_data_i,
    input  logic [num_chan_p*cnt_width_p-1:0]  target_i,
    output logic [num_chan_p-1:0]              finish_o,
    output logic                               timeout_o,
    output logic [2:0]                         error_o,
    bp_nonsynth_cosim_commit_queue_if.master   step_if
);
    localparam int ptr_w_lp  = $clog2(els_p);
    localparam int occ_w_lp  = $clog2(els_p + 1);
    localparam int chan_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int wd_w_lp   = $clog2(timeout_cycles_p + 1);
    localparam logic [wd_w_lp-1:0]  wd_max_lp = wd_w_lp'(timeout_cycles_p);
    localparam logic [occ_w_lp-1:0] full_lp   = occ_w_lp'(els_p);

    // Entry storage. Validity comes from the occupancy counters, so the
    // payload arrays need no reset. For traps the payload holds the cause,
    // for wb-pending commits it holds the writeback data.
    logic [vaddr_width_p-1:0] pc_mem_q      [num_chan_p][els_p];
    logic [vaddr_width_p-1:0] pc_mem_d      [num_chan_p][els_p];
    logic [instr_width_p-1:0] instr_mem_q   [num_chan_p][els_p];
    logic [instr_width_p-1:0] instr_mem_d   [num_chan_p][els_p];
    logic [dword_width_p-1:0] payload_mem_q [num_chan_p][els_p];
    logic [dword_width_p-1:0] payload_mem_d [num_chan_p][els_p];
    logic                     trap_mem_q    [num_chan_p][els_p];
    logic                     trap_mem_d    [num_chan_p][els_p];
    logic                     pend_mem_q    [num_chan_p][els_p];
    logic                     pend_mem_d    [num_chan_p][els_p];
    logic                     fill_mem_q    [num_chan_p][els_p];
    logic                     fill_mem_d    [num_chan_p][els_p];

    // Queue control and bookkeeping
    logic [ptr_w_lp-1:0]    rptr_q   [num_chan_p];
    logic [ptr_w_lp-1:0]    rptr_d   [num_chan_p];
    logic [ptr_w_lp-1:0]    wptr_q   [num_chan_p];
    logic [ptr_w_lp-1:0]    wptr_d   [num_chan_p];
    logic [occ_w_lp-1:0]    occ_q    [num_chan_p];
    logic [occ_w_lp-1:0]    occ_d    [num_chan_p];
    logic [cnt_width_p-1:0] retire_q [num_chan_p];
    logic [cnt_width_p-1:0] retire_d [num_chan_p];
    logic [num_chan_p-1:0]  finish_q, finish_d;
    logic [wd_w_lp-1:0]     wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             error_q, error_d;
    logic [chan_w_lp-1:0]   prio_q, prio_d;
    logic [chan_w_lp-1:0]   grant_q, grant_d;
    logic                   lock_q, lock_d;

    // Arbitration signals
    logic [num_chan_p-1:0]  head_ready;
    logic [num_chan_p-1:0]  deq;
    logic                   any_ready;
    logic                   step_v;
    logic [chan_w_lp-1:0]   rr_sel;
    logic [chan_w_lp-1:0]   sel;
    logic                   all_empty;

    // Head readiness: present and not still waiting on its writeback
    always_comb begin
        head_ready = '0;
        all_empty  = 1'b1;
        for (int c = 0; c < num_chan_p; c++) begin
            head_ready[c] = (occ_q[c] != '0) &&
                            (!pend_mem_q[c][rptr_q[c]] || fill_mem_q[c][rptr_q[c]]);
            if (occ_q[c] != '0) all_empty = 1'b0;
        end
    end

    // Round-robin pick starting at prio; a held grant overrides the pick
    always_comb begin
        any_ready = 1'b0;
        rr_sel    = '0;
        for (int k = 0; k < num_chan_p; k++) begin
            for (int c = 0; c < num_chan_p; c++) begin
                if (!any_ready && head_ready[c] &&
                    (c == ((int'(prio_q) + k) % num_chan_p))) begin
                    any_ready = 1'b1;
                    rr_sel    = chan_w_lp'(c);
                end
            end
        end
        step_v = lock_q | any_ready;
        sel    = lock_q ? grant_q : rr_sel;
        deq    = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            deq[c] = step_if.step_yumi_i && step_v && (sel == chan_w_lp'(c));
        end
    end

    // Present the selected head; fields read as zero when nothing is offered
    always_comb begin
        step_if.step_v_o     = step_v;
        step_if.step_chan_o  = step_v ? sel : '0;
        step_if.step_trap_o  = 1'b0;
        step_if.step_pc_o    = '0;
        step_if.step_instr_o = '0;
        step_if.step_data_o  = '0;
        step_if.step_cause_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            if (step_v && (sel == chan_w_lp'(c))) begin
                step_if.step_trap_o  = trap_mem_q[c][rptr_q[c]];
                step_if.step_pc_o    = pc_mem_q[c][rptr_q[c]];
                step_if.step_instr_o = instr_mem_q[c][rptr_q[c]];
                if (trap_mem_q[c][rptr_q[c]]) begin
                    step_if.step_cause_o = payload_mem_q[c][rptr_q[c]];
                end else if (pend_mem_q[c][rptr_q[c]]) begin
                    step_if.step_data_o  = payload_mem_q[c][rptr_q[c]];
                end
            end
        end
    end

    // Enqueue, writeback matching, dequeue and per-channel counters
    always_comb begin
        logic                enq_req;
        logic                enq;
        logic                found;
        logic                tgt_new;
        logic [ptr_w_lp-1:0] tgt;
        logic [ptr_w_lp-1:0] idx;
        logic [4:0]          rd;

        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
        payload_mem_d = payload_mem_q;
        trap_mem_d    = trap_mem_q;
        pend_mem_d    = pend_mem_q;
        fill_mem_d    = fill_mem_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        occ_d         = occ_q;
        retire_d      = retire_q;
        finish_d      = finish_q;
        error_d       = error_q;
        enq_req       = 1'b0;
        enq           = 1'b0;
        found         = 1'b0;
        tgt_new       = 1'b0;
        tgt           = '0;
        idx           = '0;
        rd            = '0;

        for (int c = 0; c < num_chan_p; c++) begin
            enq_req = commit_v_i[c] | trap_v_i[c];
            enq     = enq_req && ((occ_q[c] != full_lp) || deq[c]);
            if (enq_req && !enq) error_d[0] = 1'b1;

            // Oldest stored entry still waiting on a writeback
            found   = 1'b0;
            tgt_new = 1'b0;
            tgt     = '0;
            for (int k = 0; k < els_p; k++) begin
                idx = rptr_q[c] + ptr_w_lp'(k);
                if (!found && (occ_w_lp'(k) < occ_q[c]) &&
                    pend_mem_q[c][idx] && !fill_mem_q[c][idx]) begin
                    found = 1'b1;
                    tgt   = idx;
                end
            end
            // Otherwise the commit arriving this cycle may take the writeback
            if (!found && enq && !trap_v_i[c] && commit_wb_i[c]) begin
                found   = 1'b1;
                tgt     = wptr_q[c];
                tgt_new = 1'b1;
            end

            if (enq) begin
                pc_mem_d[c][wptr_q[c]]      = commit_pc_i[c*vaddr_width_p +: vaddr_width_p];
                instr_mem_d[c][wptr_q[c]]   = commit_instr_i[c*instr_width_p +: instr_width_p];
                trap_mem_d[c][wptr_q[c]]    = trap_v_i[c];
                pend_mem_d[c][wptr_q[c]]    = !trap_v_i[c] && commit_wb_i[c];
                fill_mem_d[c][wptr_q[c]]    = 1'b0;
                payload_mem_d[c][wptr_q[c]] = trap_v_i[c] ?
                    cause_i[c*dword_width_p +: dword_width_p] : '0;
                wptr_d[c] = wptr_q[c] + 1'b1;
            end

            if (wb_v_i[c]) begin
                if (found) begin
                    payload_mem_d[c][tgt] = wb_data_i[c*dword_width_p +: dword_width_p];
                    fill_mem_d[c][tgt]    = 1'b1;
                    rd = tgt_new ? commit_instr_i[c*instr_width_p+7 +: 5]
                                 : instr_mem_q[c][tgt][11:7];
                    if (rd != wb_addr_i[c*5 +: 5]) error_d[2] = 1'b1;
                end else begin
                    error_d[1] = 1'b1;
                end
            end

            if (deq[c]) begin
                rptr_d[c] = rptr_q[c] + 1'b1;
                if (!trap_mem_q[c][rptr_q[c]] && (retire_q[c] != '1)) begin
                    retire_d[c] = retire_q[c] + 1'b1;
                end
            end
            occ_d[c] = occ_q[c] + occ_w_lp'(enq) - occ_w_lp'(deq[c]);

            if ((target_i[c*cnt_width_p +: cnt_width_p] != '0) &&
                (retire_q[c] == target_i[c*cnt_width_p +: cnt_width_p])) begin
                finish_d[c] = 1'b1;
            end
        end
    end

    // Grant latch, round-robin pointer and stall watchdog
    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        if (step_if.step_yumi_i && step_v) begin
            lock_d = 1'b0;
            prio_d = (int'(sel) == num_chan_p - 1) ? '0 : sel + 1'b1;
        end else if (step_v) begin
            lock_d  = 1'b1;
            grant_d = sel;
        end

        wd_d = wd_q;
        if (step_if.step_yumi_i || all_empty) begin
            wd_d = '0;
        end else if (wd_q != wd_max_lp) begin
            wd_d = wd_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_d == wd_max_lp);
    end

    // Payload storage update
    always_ff @(posedge clk_i) begin
        pc_mem_q      <= pc_mem_d;
        instr_mem_q   <= instr_mem_d;
        payload_mem_q <= payload_mem_d;
        trap_mem_q    <= trap_mem_d;
        pend_mem_q    <= pend_mem_d;
        fill_mem_q    <= fill_mem_d;
    end

    // Control state; reset discards every entry and clears sticky flags
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int c = 0; c < num_chan_p; c++) begin
                rptr_q[c]   <= '0;
                wptr_q[c]   <= '0;
                occ_q[c]    <= '0;
                retire_q[c] <= '0;
            end
            finish_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            error_q   <= '0;
            prio_q    <= '0;
            grant_q   <= '0;
            lock_q    <= 1'b0;
        end else begin
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            occ_q     <= occ_d;
            retire_q  <= retire_d;
            finish_q  <= finish_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
            prio_q    <= prio_d;
            grant_q   <= grant_d;
            lock_q    <= lock_d;
        end
    end

    assign finish_o  = finish_q;
    assign timeout_o = timeout_q;
    assign error_o   = error_q;

`ifndef SYNTHESIS
    // The consumer may only take a record that is being offered
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!step_if.step_yumi_i || step_v);
        end
    end
`endif
endmodule

// File: tb/tb_bp_nonsynth_cosim_commit_queue.sv
// Bench for the cosim commit queue: a one-channel instance (els 8, watchdog
// 16) for the queue, writeback, error, finish and watchdog behaviour, and a
// two-channel instance for round-robin arbitration.
module tb_bp_nonsynth_cosim_commit_queue;
    localparam int VA = 39, IW = 32, DW = 64, CW = 32;

    typedef struct packed {
        logic          trap;
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic [DW-1:0] data;
        logic [DW-1:0] cause;
    } exp_t;

    typedef struct packed {
        logic          trap;
        logic          both;
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic          wb;
        logic [DW-1:0] wdata;
        logic [DW-1:0] cause;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] exp_cause;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // single-channel instance
    logic          a_commit_v = 0, a_trap_v = 0, a_commit_wb = 0, a_wb_v = 0;
    logic [VA-1:0] a_pc = '0;
    logic [IW-1:0] a_instr = '0;
    logic [DW-1:0] a_cause = '0, a_wb_data = '0;
    logic [4:0]    a_wb_addr = '0;
    logic [CW-1:0] a_target = '0;
    logic          a_finish, a_timeout;
    logic [2:0]    a_error;
    bp_nonsynth_cosim_commit_queue_if #(.num_chan_p(1)) a_if ();

    bp_nonsynth_cosim_commit_queue #(
        .num_chan_p(1), .els_p(8), .timeout_cycles_p(16)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .commit_v_i(a_commit_v), .commit_pc_i(a_pc), .commit_instr_i(a_instr),
        .commit_wb_i(a_commit_wb), .trap_v_i(a_trap_v), .cause_i(a_cause),
        .wb_v_i(a_wb_v), .wb_addr_i(a_wb_addr), .wb_data_i(a_wb_data),
        .target_i(a_target), .finish_o(a_finish), .timeout_o(a_timeout),
        .error_o(a_error), .step_if(a_if)
    );

    // two-channel instance
    logic [1:0]      b_commit_v = '0;
    logic [2*VA-1:0] b_pc = '0;
    logic [2*IW-1:0] b_instr = '0;
    logic [2*DW-1:0] b_cause = '0, b_wb_data = '0;
    logic [9:0]      b_wb_addr = '0;
    logic [2*CW-1:0] b_target = '0;
    logic [1:0]      b_finish;
    logic            b_timeout;
    logic [2:0]      b_error;
    bp_nonsynth_cosim_commit_queue_if #(.num_chan_p(2)) b_if ();

    bp_nonsynth_cosim_commit_queue #(
        .num_chan_p(2), .els_p(4)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .commit_v_i(b_commit_v), .commit_pc_i(b_pc), .commit_instr_i(b_instr),
        .commit_wb_i(2'b00), .trap_v_i(2'b00), .cause_i(b_cause),
        .wb_v_i(2'b00), .wb_addr_i(b_wb_addr), .wb_data_i(b_wb_data),
        .target_i(b_target), .finish_o(b_finish), .timeout_o(b_timeout),
        .error_o(b_error), .step_if(b_if)
    );

    exp_t          sb_a[$];
    logic [VA-1:0] sb_b0[$];
    logic [VA-1:0] sb_b1[$];
    vec_t          vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_a(input logic cv, input logic tv, input logic cwb,
                           input logic [VA-1:0] pc, input logic [IW-1:0] instr,
                           input logic [DW-1:0] cause, input logic wv,
                           input logic [4:0] wa, input logic [DW-1:0] wd);
        a_commit_v = cv; a_trap_v = tv; a_commit_wb = cwb; a_pc = pc;
        a_instr = instr; a_cause = cause; a_wb_v = wv; a_wb_addr = wa; a_wb_data = wd;
        tick();
        a_commit_v = 1'b0; a_trap_v = 1'b0; a_commit_wb = 1'b0; a_wb_v = 1'b0;
    endtask

    task automatic push_a(input logic trap, input logic [VA-1:0] pc, input logic [IW-1:0] instr,
                          input logic [DW-1:0] data, input logic [DW-1:0] cause);
        exp_t e;
        e.trap = trap; e.pc = pc; e.instr = instr; e.data = data; e.cause = cause;
        sb_a.push_back(e);
    endtask

    // compare the offered record with the scoreboard head, then take it
    task automatic consume_a(input string nm);
        exp_t e;
        check({nm, "_v"}, 64'(a_if.step_v_o), 64'd1);
        if (sb_a.size() == 0) begin
            n_checks++;
            $display("FAIL %s_sb: got empty scoreboard expected a record", nm);
        end else if (a_if.step_v_o) begin
            e = sb_a.pop_front();
            check({nm, "_pc"}, 64'(a_if.step_pc_o), 64'(e.pc));
            check({nm, "_instr"}, 64'(a_if.step_instr_o), 64'(e.instr));
            check({nm, "_data"}, a_if.step_data_o, e.data);
            check({nm, "_cause"}, a_if.step_cause_o, e.cause);
            check({nm, "_trap"}, 64'(a_if.step_trap_o), 64'(e.trap));
            check({nm, "_chan"}, 64'(a_if.step_chan_o), 64'd0);
            a_if.step_yumi_i = 1'b1;
            tick();
            a_if.step_yumi_i = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [VA-1:0] pcv;
        a_if.step_yumi_i = 1'b0;
        b_if.step_yumi_i = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 39'h1000, 32'h00000013, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[1] = '{1'b0, 1'b0, 39'h1004, 32'h00a00293, 1'b1, 64'h1111, 64'h0, 64'h1111, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 39'h1008, 32'h00000000, 1'b0, 64'h0, 64'h8000000000000007, 64'h0, 64'h8000000000000007};
        vecs[3] = '{1'b0, 1'b0, 39'h100c, 32'h00b00313, 1'b1, 64'hffffffffffffffff, 64'h0, 64'hffffffffffffffff, 64'h0};
        vecs[4] = '{1'b0, 1'b0, 39'h7ffffffffc, 32'h000003b7, 1'b1, 64'h0123456789abcdef, 64'h0, 64'h0123456789abcdef, 64'h0};
        vecs[5] = '{1'b1, 1'b1, 39'h2000, 32'h00a00293, 1'b0, 64'h0, 64'h3, 64'h0, 64'h3};
        vecs[6] = '{1'b0, 1'b0, 39'h2004, 32'h00000073, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0};

        do_reset();
        check("rst_step_v", 64'(a_if.step_v_o), 64'd0);
        check("rst_step_pc", 64'(a_if.step_pc_o), 64'd0);
        check("rst_error", 64'(a_error), 64'd0);
        check("rst_finish", 64'(a_finish), 64'd0);
        check("rst_timeout", 64'(a_timeout), 64'd0);
        check("rst_b_step_v", 64'(b_if.step_v_o), 64'd0);

        // single commit without writeback, held for five cycles
        drive_a(1, 0, 0, 39'h80000000, 32'h00000013, '0, 0, '0, '0);
        push_a(0, 39'h80000000, 32'h00000013, '0, '0);
        check("hold_v0", 64'(a_if.step_v_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_pc", 64'(a_if.step_pc_o), 64'h80000000);
        end
        consume_a("hold");
        check("hold_after_v", 64'(a_if.step_v_o), 64'd0);

        // writeback arriving three cycles after its commit
        drive_a(1, 0, 1, 39'h80000004, 32'h00a00293, '0, 0, '0, '0);
        push_a(0, 39'h80000004, 32'h00a00293, 64'hdead, '0);
        check("wb_wait0", 64'(a_if.step_v_o), 64'd0);
        tick();
        check("wb_wait1", 64'(a_if.step_v_o), 64'd0);
        tick();
        check("wb_wait2", 64'(a_if.step_v_o), 64'd0);
        drive_a(0, 0, 0, '0, '0, '0, 1, 5'd5, 64'hdead);
        consume_a("wb_late");
        check("wb_late_err", 64'(a_error), 64'd0);

        // table: one record per cycle, writebacks in the same cycle
        for (int i = 0; i < 7; i++) begin
            drive_a(!vecs[i].trap || vecs[i].both, vecs[i].trap,
                    vecs[i].wb || vecs[i].both, vecs[i].pc, vecs[i].instr,
                    vecs[i].cause, vecs[i].wb, vecs[i].instr[11:7], vecs[i].wdata);
            push_a(vecs[i].trap, vecs[i].pc, vecs[i].instr, vecs[i].exp_data, vecs[i].exp_cause);
        end
        for (int i = 0; i < 7; i++) consume_a("vec");
        check("vec_err", 64'(a_error), 64'd0);
        check("vec_empty", 64'(a_if.step_v_o), 64'd0);

        // overflow: nine commits into eight slots
        do_reset();
        for (int i = 0; i < 9; i++) begin
            pcv = 39'h3000 + 39'(4 * i);
            drive_a(1, 0, 0, pcv, 32'h00000013, '0, 0, '0, '0);
            if (i < 8) push_a(0, pcv, 32'h00000013, '0, '0);
        end
        check("ovf_err", 64'(a_error), 64'd1);
        for (int i = 0; i < 8; i++) consume_a("ovf");
        check("ovf_empty", 64'(a_if.step_v_o), 64'd0);

        // orphan writeback
        do_reset();
        drive_a(0, 0, 0, '0, '0, '0, 1, 5'd5, 64'h1);
        check("orphan_err", 64'(a_error), 64'd2);

        // writeback address differs from rd; data is still delivered
        do_reset();
        drive_a(1, 0, 1, 39'h4000, 32'h00a00293, '0, 0, '0, '0);
        push_a(0, 39'h4000, 32'h00a00293, 64'hbeef, '0);
        drive_a(0, 0, 0, '0, '0, '0, 1, 5'd6, 64'hbeef);
        check("mism_err", 64'(a_error), 64'd4);
        consume_a("mism");

        // finish after four retired records
        do_reset();
        a_target = 32'd4;
        for (int i = 0; i < 4; i++) begin
            pcv = 39'h5000 + 39'(4 * i);
            drive_a(1, 0, 0, pcv, 32'h00000013, '0, 0, '0, '0);
            push_a(0, pcv, 32'h00000013, '0, '0);
            consume_a("fin");
            if (i == 2) check("fin_early", 64'(a_finish), 64'd0);
        end
        tick();
        check("fin_set", 64'(a_finish), 64'd1);
        tick();
        tick();
        check("fin_sticky", 64'(a_finish), 64'd1);
        a_target = '0;

        // watchdog with one stuck record, then reset mid-operation
        do_reset();
        drive_a(1, 0, 1, 39'h6000, 32'h00a00293, '0, 0, '0, '0);
        for (int i = 0; i < 15; i++) tick();
        check("wd_before", 64'(a_timeout), 64'd0);
        tick();
        check("wd_fire", 64'(a_timeout), 64'd1);
        tick();
        check("wd_sticky", 64'(a_timeout), 64'd1);
        do_reset();
        check("midrst_v", 64'(a_if.step_v_o), 64'd0);
        check("midrst_timeout", 64'(a_timeout), 64'd0);

        // two channels: both always ready, consumer always takes
        for (int i = 0; i < 4; i++) begin
            b_commit_v = 2'b11;
            b_pc = {39'h200 + 39'(4 * i), 39'h100 + 39'(4 * i)};
            b_instr = {32'h00000013, 32'h00000013};
            sb_b0.push_back(39'h100 + 39'(4 * i));
            sb_b1.push_back(39'h200 + 39'(4 * i));
            tick();
        end
        b_commit_v = 2'b00;
        for (int i = 0; i < 8; i++) begin
            check("rr_v", 64'(b_if.step_v_o), 64'd1);
            check("rr_chan", 64'(b_if.step_chan_o), 64'(i % 2));
            if ((i % 2) == 0) begin
                if (sb_b0.size() > 0) check("rr_pc0", 64'(b_if.step_pc_o), 64'(sb_b0.pop_front()));
            end else begin
                if (sb_b1.size() > 0) check("rr_pc1", 64'(b_if.step_pc_o), 64'(sb_b1.pop_front()));
            end
            if (b_if.step_v_o) begin
                b_if.step_yumi_i = 1'b1;
                tick();
                b_if.step_yumi_i = 1'b0;
            end
        end
        check("rr_empty", 64'(b_if.step_v_o), 64'd0);
        check("rr_err", 64'(b_error), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
